// File: rtl/dma_pkg.sv
// Widths, FSM states and app-facing structs shared by the DMA copy engine and the app.
package dma_pkg;

  localparam int ADDR_W = 42;
  localparam int DATA_W = 512;
  localparam int LEN_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } t_dma_state;

  typedef struct packed {
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [LEN_W-1:0]  rd_len;
    logic [LEN_W-1:0]  wr_len;
    logic              begin_copy;
    logic              rd_ready;
    logic              wr_out;
    logic [DATA_W-1:0] wr_data;
  } t_dma_in;

  typedef struct packed {
    logic              rd_out;
    logic [DATA_W-1:0] rd_data;
    logic              wr_ready;
    logic              done;
    logic              err_overrun;
  } t_dma_out;

  // Line addresses wrap modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [LEN_W-1:0]  idx);
    return base + ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/dma_rd_fifo.sv
// Synchronous FIFO buffering read-response lines until the app takes them.
module dma_rd_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (PTR_W+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Read credit is reserved at issue time, so a full FIFO can never see a push.
  assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/dma_copy_engine.sv
// Copy engine: streams source lines from host memory to the app and writes the app's
// echoed lines back to the destination, signalling done once both directions finish.
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int RD_FIFO_DEPTH      = 64,
  parameter int MAX_RD_OUTSTANDING = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  rd_len,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic              begin_copy,
  input  logic              rd_ready,
  output logic              rd_out,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_ready,
  input  logic              wr_out,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_rd_req_valid,
  output logic [ADDR_W-1:0] mem_rd_req_addr,
  input  logic              mem_rd_almfull,
  input  logic              mem_rd_rsp_valid,
  input  logic [DATA_W-1:0] mem_rd_rsp_data,
  output logic              mem_wr_req_valid,
  output logic [ADDR_W-1:0] mem_wr_req_addr,
  output logic [DATA_W-1:0] mem_wr_req_data,
  input  logic              mem_wr_almfull,
  input  logic              mem_wr_rsp_valid,
  output logic              done,
  output logic              err_overrun
);

  localparam int CNT_W = $clog2(RD_FIFO_DEPTH) + 1;

  t_dma_state        state;
  logic              begin_q;
  logic [ADDR_W-1:0] rd_base, wr_base;
  logic [LEN_W-1:0]  rd_len_q, wr_len_q;
  logic [LEN_W-1:0]  rd_issued, rd_rcvd, rd_delivered;
  logic [LEN_W-1:0]  wr_accepted, wr_acked, wr_acc_next;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, fifo_full;
  logic [DATA_W-1:0] fifo_head;
  logic [LEN_W:0]    in_flight;
  logic              running, start, push, pop, issue, wr_accept, all_done;

  assign running  = (state == RUN);
  assign start    = (state == IDLE) && begin_copy && !begin_q;
  // Responses with nothing outstanding (e.g. stragglers from before a reset) are dropped.
  assign push     = running && mem_rd_rsp_valid && (rd_rcvd != rd_issued);
  assign pop      = running && rd_ready && !fifo_empty && !rd_out;
  assign in_flight = {1'b0, rd_issued - rd_rcvd} + (LEN_W+1)'(fifo_count);
  assign issue    = running && (rd_issued < rd_len_q) && !mem_rd_almfull &&
                    (in_flight < (LEN_W+1)'(MAX_RD_OUTSTANDING));
  assign wr_accept   = running && wr_out && (wr_accepted < wr_len_q);
  assign wr_acc_next = wr_accepted + LEN_W'(wr_accept);
  assign all_done = (rd_rcvd == rd_len_q) && (rd_delivered == rd_len_q) &&
                    (wr_acked == wr_len_q);

  dma_rd_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(RD_FIFO_DEPTH)
  ) u_rd_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(mem_rd_rsp_data),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      begin_q          <= 1'b0;
      rd_base          <= '0;
      wr_base          <= '0;
      rd_len_q         <= '0;
      wr_len_q         <= '0;
      rd_issued        <= '0;
      rd_rcvd          <= '0;
      rd_delivered     <= '0;
      wr_accepted      <= '0;
      wr_acked         <= '0;
      rd_out           <= 1'b0;
      rd_data          <= '0;
      wr_ready         <= 1'b0;
      mem_rd_req_valid <= 1'b0;
      mem_rd_req_addr  <= '0;
      mem_wr_req_valid <= 1'b0;
      mem_wr_req_addr  <= '0;
      mem_wr_req_data  <= '0;
      done             <= 1'b0;
      err_overrun      <= 1'b0;
    end else begin
      begin_q          <= begin_copy;
      rd_out           <= 1'b0;
      mem_rd_req_valid <= 1'b0;
      mem_wr_req_valid <= 1'b0;
      // Uses the post-accept count so wr_ready drops right after the last line.
      wr_ready <= running && !mem_wr_almfull && (wr_acc_next < wr_len_q);

      case (state)
        IDLE: if (start) begin
          state        <= RUN;
          rd_base      <= rd_addr;
          wr_base      <= wr_addr;
          rd_len_q     <= rd_len;
          wr_len_q     <= wr_len;
          rd_issued    <= '0;
          rd_rcvd      <= '0;
          rd_delivered <= '0;
          wr_accepted  <= '0;
          wr_acked     <= '0;
        end
        RUN: if (all_done) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: if (!begin_copy) begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (issue) begin
        mem_rd_req_valid <= 1'b1;
        mem_rd_req_addr  <= line_addr(rd_base, rd_issued);
        rd_issued        <= rd_issued + LEN_W'(1);
      end
      if (push) rd_rcvd <= rd_rcvd + LEN_W'(1);
      if (pop) begin
        rd_out       <= 1'b1;
        rd_data      <= fifo_head;
        rd_delivered <= rd_delivered + LEN_W'(1);
      end

      // Writes issue even if almfull rose meanwhile; the channel has slack for them.
      if (wr_accept) begin
        mem_wr_req_valid <= 1'b1;
        mem_wr_req_addr  <= line_addr(wr_base, wr_accepted);
        mem_wr_req_data  <= wr_data;
        wr_accepted      <= wr_acc_next;
      end else if (wr_out) begin
        err_overrun <= 1'b1;
      end
      if (running && mem_wr_rsp_valid && (wr_acked < wr_len_q))
        wr_acked <= wr_acked + LEN_W'(1);
    end
  end

endmodule
